if_stage_fetch: RTL and testbench
=================================

# if_stage_fetch

Instruction fetch stage of the ARM pipeline. It is the block directly upstream of the decode stage and owns the program counter. It issues word fetches to an external variable-latency instruction memory and buffers returned words in a small fetch queue. It presents one instruction plus PC+4 per cycle to decode through an internal IF/ID output register. Decode hazards freeze it, and taken branches from execute redirect and flush it.

## Interface
- FQ_DEPTH, 2: fetch-queue entries; also the maximum outstanding plus buffered fetches (2..4).
- RESET_PC, 32'h0000_0000: PC after reset.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- freeze  in  1  hazard stall from decode; holds the IF/ID output and PC.
- branch_taken  in  1  taken branch from execute; one-cycle pulse.
- branch_addr  in  32  branch target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request (current fetch PC).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in order, latency ≥1 cycle.
- imem_rdata  in  32  response instruction word.
- valid  out  1  IF/ID holds a real instruction.
- instruction  out  32  IF/ID instruction; 32'h0 when `valid`=0.
- PC  out  32  IF/ID address of that instruction plus 4.

## Operation
- Credit rule: `imem_req` = `rst` & ~`branch_taken` & (outstanding + queue_count < FQ_DEPTH).
  - A request is issued on `imem_req` & `imem_ready`.
  - On issue, fetch_pc += 4, outstanding += 1, and the queue entry records PC+4 for that word.
- Response handling:
  - `imem_rvalid` with kill_cnt=0: push {rdata, pc+4}; outstanding -= 1.
  - `imem_rvalid` with kill_cnt>0: drop the word; kill_cnt -= 1; outstanding -= 1.
- Response into a full queue cannot occur because of the credit rule; a bench assertion flags it.
- IF/ID update when ~`freeze`:
  - Queue non-empty: pop the head into `instruction`/`PC` and set `valid`=1.
  - Queue empty: load a bubble (`valid`=0, `instruction`=0, `PC` unchanged).
- When `freeze`=1: the IF/ID register and queue head are held. Fetches still issue and responses are still accepted while credits remain.
- Branch, with `branch_taken` priority over `freeze` and over any pop:
  - Next cycle, IF/ID is a bubble.
  - The queue is emptied.
  - kill_cnt <= outstanding minus any response kept/dropped in this same cycle.
  - fetch_pc <= {branch_addr[31:2],2'b00}.
  - No request is issued during the branch cycle.
- Requests issue normally while kill_cnt>0. New responses are only enqueued once kill_cnt reaches 0.
- Arithmetic: PC wraps modulo 2^32. Counters are sized $clog2(FQ_DEPTH+1).

## Timing
- Reset values:
  - fetch_pc=RESET_PC; outstanding=0; kill_cnt=0; queue empty.
  - `valid`=0, `instruction`=0, `PC`=0, `imem_req`=0.
  - `imem_addr`=RESET_PC.
- Reset asserted mid-operation clears everything above immediately. In-flight memory responses after reset release are the memory's responsibility; the memory is reset together with this block.
- Minimum fetch latency, with memory latency 1 and no stalls:
  - request in cycle N, response in N+1, `valid` in N+2.
  - Steady state is one instruction per cycle when FQ_DEPTH ≥ 2.
- Branch penalty: with a branch in cycle B, the first target request issues in B+1, and a target instruction reaches `valid` in B+3 at the earliest.
- `imem_addr` is stable while `imem_req`=1 and `imem_ready`=0.

## Configuration
- IF_FETCH_STATS_EN defined:
  - Adds outputs `stat_fetched` (32) and `stat_bubbles` (32), both reset to 0 and wrapping.
  - `stat_fetched` counts IF/ID loads with `valid`=1.
  - `stat_bubbles` counts IF/ID bubble loads, excluding freeze cycles.
- IF_FETCH_STATS_EN undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset release, memory latency 1, always ready → `imem_addr` 0,4,8,…; `valid` first high 2 cycles later with `PC`=4, then `PC`=8, 12 on consecutive cycles.
- `imem_ready`=0 for 3 cycles → `imem_addr` held at 8; no duplicate or skipped instruction; `PC` sequence resumes 12, 16.
- `freeze` high 4 cycles with the queue filling → `instruction`/`PC` held; `imem_req` drops once outstanding+count=FQ_DEPTH; after release, words emerge in order with no loss.
- `branch_taken` with branch_addr=32'h103 and 2 fetches outstanding, latency 2 → next-cycle bubble; both stale responses dropped; first valid `PC`=32'h104 with the word from address 32'h100.
- `branch_taken` and `freeze` together → branch wins: bubble next cycle, redirect to the target.
- Async `rst` low mid-stream, with responses pending and the memory reset too → all outputs return to reset values within the same cycle; fetch restarts at RESET_PC. With IF_FETCH_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/if_stage_fetch.sv
// if_stage_fetch
//   Instruction fetch stage. Owns the fetch PC and issues word fetches to a
//   variable-latency, in-order instruction memory. Returned words are buffered
//   in a small fetch queue and presented one per cycle to decode through the
//   IF/ID output register. Decode freezes hold IF/ID. Taken branches flush the
//   queue, kill in-flight responses and redirect the fetch PC.
//
//   Optional build macro IF_FETCH_STATS_EN adds the stat_fetched/stat_bubbles
//   counters and their ports.
//
// Parameters
//   FQ_DEPTH     fetch-queue entries and fetch credit limit (2..4)
//   RESET_PC     fetch PC after reset
// Ports
//   clk          pipeline clock, rising edge
//   rst          asynchronous active-low reset
//   freeze       hazard stall from decode, holds IF/ID and the queue head
//   branch_taken taken-branch pulse from execute
//   branch_addr  branch target, low two bits ignored
//   imem_req     fetch request valid
//   imem_addr    fetch word address (current fetch PC)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   response instruction word
//   valid        IF/ID holds a real instruction
//   instruction  IF/ID instruction, zero for a bubble
//   PC           IF/ID instruction address plus 4
//   stat_fetched valid IF/ID loads (IF_FETCH_STATS_EN only)
//   stat_bubbles bubble IF/ID loads outside freeze (IF_FETCH_STATS_EN only)
module if_stage_fetch #(
  parameter int unsigned FQ_DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] PC
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_bubbles
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FQ_DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  // Fetch / credit state
  logic [31:0] fetch_pc;
  cnt_t        outstanding;
  cnt_t        kill_cnt;
  cnt_t        out_nxt;

  // Fetch queue
  logic [31:0] q_instr [FQ_DEPTH];
  logic [31:0] q_pc4   [FQ_DEPTH];
  ptr_t        q_head;
  ptr_t        q_tail;
  cnt_t        q_count;
  cnt_t        q_count_nxt;

  // Per-cycle control
  logic        issue;
  logic        resp_keep;
  logic        resp_drop;
  logic        q_empty;
  logic        do_pop;
  logic        do_push;
  logic        bypass;
  logic [31:0] resp_pc4;
  sum_t        credit_used;

  // Branch targets are word aligned; the low bits are deliberately discarded.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^branch_addr[1:0];

  assign credit_used = sum_t'(outstanding) + sum_t'(q_count);
  assign imem_req    = rst & ~branch_taken & (credit_used < sum_t'(FQ_DEPTH));
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req & imem_ready;

  assign resp_keep = imem_rvalid & (kill_cnt == '0);
  assign resp_drop = imem_rvalid & (kill_cnt != '0);
  assign q_empty   = (q_count == '0);

  // Once no kills remain, every outstanding request is a contiguous run ending
  // just below fetch_pc, so the oldest one sits outstanding words back. This
  // replaces a per-request address FIFO.
  assign resp_pc4 = fetch_pc - (32'(outstanding) << 2) + 32'd4;

  // A response arriving at an empty, unfrozen queue goes straight to IF/ID so
  // a latency-1 fetch reaches decode two cycles after the request.
  assign do_pop  = ~branch_taken & ~freeze & ~q_empty;
  assign bypass  = ~branch_taken & ~freeze & q_empty & resp_keep;
  assign do_push = ~branch_taken & resp_keep & ~bypass;

  always_comb begin
    out_nxt = outstanding;
    if (issue)       out_nxt = out_nxt + cnt_t'(1);
    if (imem_rvalid) out_nxt = out_nxt - cnt_t'(1);
  end

  always_comb begin
    q_count_nxt = q_count;
    if (do_push) q_count_nxt = q_count_nxt + cnt_t'(1);
    if (do_pop)  q_count_nxt = q_count_nxt - cnt_t'(1);
  end

  // Fetch PC, outstanding count and kill count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (branch_taken) begin
        fetch_pc <= {branch_addr[31:2], 2'b00};
        // No request issues in a branch cycle, so out_nxt is exactly the
        // in-flight count left after this cycle's response; all are stale.
        kill_cnt <= out_nxt;
      end else begin
        if (issue)     fetch_pc <= fetch_pc + 32'd4;
        if (resp_drop) kill_cnt <= kill_cnt - cnt_t'(1);
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else if (branch_taken) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      q_count <= q_count_nxt;
      if (do_push) q_tail <= ptr_inc(q_tail);
      if (do_pop)  q_head <= ptr_inc(q_head);
    end
  end

  // Queue storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_instr[q_tail] <= imem_rdata;
      q_pc4[q_tail]   <= resp_pc4;
    end
  end

  // IF/ID output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= 1'b0;
      instruction <= '0;
      PC          <= '0;
    end else if (branch_taken) begin
      valid       <= 1'b0;
      instruction <= '0;
    end else if (!freeze) begin
      if (!q_empty) begin
        valid       <= 1'b1;
        instruction <= q_instr[q_head];
        PC          <= q_pc4[q_head];
      end else if (resp_keep) begin
        valid       <= 1'b1;
        instruction <= imem_rdata;
        PC          <= resp_pc4;
      end else begin
        valid       <= 1'b0;
        instruction <= '0;
      end
    end
  end

`ifdef IF_FETCH_STATS_EN
  logic load_valid;
  logic load_bubble;

  assign load_valid  = ~branch_taken & ~freeze & (~q_empty | resp_keep);
  assign load_bubble = ~freeze & (branch_taken | (q_empty & ~resp_keep));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_bubbles <= '0;
    end else begin
      if (load_valid)  stat_fetched <= stat_fetched + 32'd1;
      if (load_bubble) stat_bubbles <= stat_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
module tb_if_stage_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] PC;
`ifdef IF_FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_bubbles;
`endif

  always #5 clk = ~clk;

  if_stage_fetch #(.FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .instruction  (instruction),
    .PC           (PC)
`ifdef IF_FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_bubbles (stat_bubbles)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Memory model: in-order responses with per-request due cycle
  int          cyc      = 0;
  int          lat      = 1;
  int          last_due = -1;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  // Program-order reference: credits in use, words held inside the stage,
  // stale responses still to drop, next fetch address, next decode PC.
  int          out_m;
  int          buf_m;
  int          kill_m;
  logic [31:0] fetch_m;
  logic [31:0] exp_pc4;
  logic        prev_valid;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic        last_req;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_addr.delete();
    pend_due.delete();
    last_due    = -1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    out_m       = 0;
    buf_m       = 0;
    kill_m      = 0;
    fetch_m     = RPC;
    exp_pc4     = RPC + 32'd4;
    prev_valid  = 1'b0;
    prev_instr  = '0;
    prev_pc     = '0;
  endtask

  // One clock cycle: sample the request before the edge, then check IF/ID
  // just after the edge and drive the next memory response.
  task automatic cycle();
    logic        in_br, in_fz, in_rv, in_rdy, req_s, kept;
    logic [31:0] in_ba, addr_s, tgt;
    int          due;
    @(negedge clk);
    in_br  = branch_taken;
    in_fz  = freeze;
    in_rv  = imem_rvalid;
    in_rdy = imem_ready;
    in_ba  = branch_addr;
    req_s  = imem_req;
    addr_s = imem_addr;
    last_req = req_s;
    chk("imem_req", {31'd0, req_s},
        {31'd0, rst && !in_br && (out_m + buf_m < int'(DEPTH))});
    if (req_s) chk("imem_addr", addr_s, fetch_m);
    if (in_rv && kill_m == 0) chk("queue_room", {31'd0, buf_m < int'(DEPTH)}, 32'd1);

    @(posedge clk);
    #1;
    cyc++;
    kept = 1'b0;
    if (in_rv) begin
      if (pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      out_m--;
      if (kill_m > 0) kill_m--;
      else kept = 1'b1;
    end
    tgt = {in_ba[31:2], 2'b00};
    if (in_br) begin
      kill_m  = out_m;
      buf_m   = 0;
      fetch_m = tgt;
    end else if (kept) begin
      buf_m++;
    end
    if (req_s && in_rdy) begin
      due = cyc + lat - 1;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(addr_s);
      pend_due.push_back(due);
      out_m++;
      if (!in_br) fetch_m = fetch_m + 32'd4;
    end

    if (in_br) begin
      exp_pc4 = tgt + 32'd4;
      chk("branch_bubble_valid", {31'd0, valid}, 32'd0);
      chk("branch_bubble_instr", instruction, 32'd0);
      chk("branch_bubble_pc", PC, prev_pc);
    end else if (in_fz) begin
      chk("freeze_valid", {31'd0, valid}, {31'd0, prev_valid});
      chk("freeze_instr", instruction, prev_instr);
      chk("freeze_pc", PC, prev_pc);
    end else if (buf_m > 0) begin
      chk("issue_valid", {31'd0, valid}, 32'd1);
      chk("issue_pc", PC, exp_pc4);
      chk("issue_instr", instruction, memfn(exp_pc4 - 32'd4));
      exp_pc4 = exp_pc4 + 32'd4;
      buf_m--;
    end else begin
      chk("bubble_valid", {31'd0, valid}, 32'd0);
      chk("bubble_instr", instruction, 32'd0);
      chk("bubble_pc", PC, prev_pc);
    end
    prev_valid = valid;
    prev_instr = instruction;
    prev_pc    = PC;

    if (rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    logic [31:0] a0;
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b1;
    model_reset();

    // Reset values
    cycle();
    cycle();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
`ifdef IF_FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'd0);
    chk("rst_stat_bubbles", stat_bubbles, 32'd0);
`endif

    // Minimum latency and streaming, memory latency 1
    rst = 1'b1;
    lat = 1;
    cycle();
    chk("lat_first_not_yet", {31'd0, valid}, 32'd0);
    cycle();
    chk("lat_first_valid", {31'd0, valid}, 32'd1);
    chk("lat_first_pc", PC, RPC + 32'd4);
    cycle();
    chk("stream_pc8", PC, RPC + 32'd8);
    cycle();
    chk("stream_pc12", PC, RPC + 32'd12);

    // Memory back-pressure: address holds while not accepted
    imem_ready = 1'b0;
    a0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_addr_hold", imem_addr, a0);
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Freeze with the queue filling; requests stop once credits run out
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("freeze_req_dropped", {31'd0, last_req}, 32'd0);
    freeze = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Branch with two fetches in flight, latency 2
    lat = 2;
    for (int i = 0; i < 20 && out_m != 2; i++) cycle();
    chk("branch_setup_outstanding", 32'(out_m), 32'd2);
    branch_addr  = 32'h0000_0103;
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    for (int i = 0; i < 20 && !valid; i++) cycle();
    chk("branch_target_valid", {31'd0, valid}, 32'd1);
    chk("branch_target_pc", PC, 32'h0000_0104);
    chk("branch_target_instr", instruction, memfn(32'h0000_0100));
    for (int i = 0; i < 4; i++) cycle();

    // Branch and freeze together: branch wins
    lat = 1;
    freeze = 1'b1;
    cycle();
    branch_addr  = 32'h0000_2000;
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    cycle();
    freeze = 1'b0;
    for (int i = 0; i < 20 && !valid; i++) cycle();
    chk("brfz_target_pc", PC, 32'h0000_2004);

    // PC wrap at the top of the address space
    branch_addr  = 32'hFFFF_FFF8;
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    for (int i = 0; i < 20 && !valid; i++) cycle();
    chk("wrap_pc_first", PC, 32'hFFFF_FFFC);
    cycle();
    for (int i = 0; i < 20 && !valid; i++) cycle();
    chk("wrap_pc_zero", PC, 32'h0000_0000);
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic against the program-order model
    for (int i = 0; i < 1500; i++) begin
      imem_ready   = ($urandom_range(0, 9) < 7);
      freeze       = ($urandom_range(0, 9) < 2);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_addr  = $urandom;
      lat          = $urandom_range(1, 4);
      cycle();
    end
    freeze       = 1'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    lat          = 3;
    for (int i = 0; i < 6; i++) cycle();

    // Asynchronous reset mid-stream, memory reset alongside
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_instr", instruction, 32'd0);
    chk("arst_pc", PC, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, RPC);
`ifdef IF_FETCH_STATS_EN
    chk("arst_stat_fetched", stat_fetched, 32'd0);
    chk("arst_stat_bubbles", stat_bubbles, 32'd0);
`endif
    model_reset();
    cycle();
    rst = 1'b1;
    lat = 1;
    cycle();
    cycle();
    chk("restart_pc", PC, RPC + 32'd4);
    for (int i = 0; i < 4; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
